// File: rtl/cpu_ctrl_fsm_v2.sv
// cpu_ctrl_fsm_v2: Moore control FSM for the 16-bit SIMPLE-RISC datapath.
// Sequences fetch, decode, ALU ops, LDR/STR, conditional branch, BL/BX/BLX.
// Memory read latency is set by MEM_LAT through a wait-state counter.
// Optional build macro CPU_CTRL_TRAP_EN: undefined instructions park in a
// sticky trap (halted=1) instead of retiring as a one-cycle NOP.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// RST      | reset PC, then start fetching
// IF1      | instruction read pending, held MEM_LAT cycles
// IF2      | read data valid, capture into IR
// UPD_PC   | PC <= PC+1
// DECODE   | dispatch on opcode/op
// MOVI     | Rn <= sximm8
// GET_A    | A <= Rn
// GET_B    | B <= Rm
// EXEC     | C <= ALU result (status for CMP)
// WB       | Rd <= C
// LD_A     | A <= Rn (LDR base)
// LD_C     | C <= Rn + sximm5
// LD_ADDR  | address register <= C
// LD_MEM   | data read pending, held MEM_LAT cycles
// LD_WB    | Rd <= mdata
// ST_A     | A <= Rn (STR base)
// ST_C     | C <= Rn + sximm5
// ST_ADDR  | address register <= C
// ST_B     | B <= Rd (store data)
// ST_PASS  | C <= B (pass-through)
// ST_MEM   | memory write
// BR       | conditional branch to PC+sximm8
// BL       | link PC into Rn and branch
// BX_B     | B <= Rd (target)
// BX_C     | C <= B
// BX_J     | PC <= C, BLX also links into Rn
// HALT     | stopped until reset
// UNDEF    | undefined instruction (NOP or sticky trap)

module cpu_ctrl_fsm_v2 #(
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = $clog2(MEM_LAT + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  input  logic [2:0] cond,
  input  logic       Z,
  input  logic       N,
  input  logic       V,
  output logic [2:0] nsel,
  output logic [1:0] vsel,
  output logic       write,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic       load_ir,
  output logic       load_pc,
  output logic       reset_pc,
  output logic       load_addr,
  output logic       addr_sel,
  output logic [1:0] pc_sel,
  output logic [1:0] mem_cmd,
  output logic       halted
);

  typedef enum logic [4:0] {
    S_RST, S_IF1, S_IF2, S_UPD_PC, S_DECODE, S_MOVI,
    S_GET_A, S_GET_B, S_EXEC, S_WB,
    S_LD_A, S_LD_C, S_LD_ADDR, S_LD_MEM, S_LD_WB,
    S_ST_A, S_ST_C, S_ST_ADDR, S_ST_B, S_ST_PASS, S_ST_MEM,
    S_BR, S_BL, S_BX_B, S_BX_C, S_BX_J,
    S_HALT, S_UNDEF
  } state_t;

  localparam logic [2:0] NSEL_RN = 3'b100;
  localparam logic [2:0] NSEL_RD = 3'b010;
  localparam logic [2:0] NSEL_RM = 3'b001;

  localparam logic [1:0] VSEL_MDATA = 2'b00;
  localparam logic [1:0] VSEL_IMM   = 2'b01;
  localparam logic [1:0] VSEL_PC    = 2'b10;
  localparam logic [1:0] VSEL_C     = 2'b11;

  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_REL = 2'b01;
  localparam logic [1:0] PC_REG = 2'b10;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_WRITE = 2'b01;
  localparam logic [1:0] MEM_READ  = 2'b10;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             wait_done;
  logic             br_taken;
  logic             is_cmp;
  logic             is_pass_a;

  assign wait_done = (cnt == CNT_LAST);
  assign is_cmp    = (opcode == 3'b101) && (op == 2'b01);
  // MOV-reg and MVN route B straight through, so the A operand is masked.
  assign is_pass_a = ((opcode == 3'b110) && (op == 2'b00)) ||
                     ((opcode == 3'b101) && (op == 2'b11));

  // Branch condition evaluation from the status flags.
  always_comb begin
    br_taken = 1'b0;
    case (cond)
      3'b000:  br_taken = 1'b1;
      3'b001:  br_taken = Z;
      3'b010:  br_taken = ~Z;
      3'b011:  br_taken = N ^ V;
      3'b100:  br_taken = (N ^ V) | Z;
      default: br_taken = 1'b0;
    endcase
  end

  // State and wait counter registers; synchronous reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_RST;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Wait counter: counts only while a wait state loops on itself, so it
  // restarts from zero on every entry and stops at MEM_LAT-1.
  always_comb begin
    cnt_next = '0;
    if (((state == S_IF1) || (state == S_LD_MEM)) && (state_next == state))
      cnt_next = cnt + CNT_W'(1);
  end

  // Next-state logic and Moore outputs.
  always_comb begin
    state_next = state;
    nsel       = NSEL_RM;
    vsel       = VSEL_C;
    write      = 1'b0;
    loada      = 1'b0;
    loadb      = 1'b0;
    loadc      = 1'b0;
    loads      = 1'b0;
    asel       = 1'b0;
    bsel       = 1'b0;
    load_ir    = 1'b0;
    load_pc    = 1'b0;
    reset_pc   = 1'b0;
    load_addr  = 1'b0;
    addr_sel   = 1'b0;
    pc_sel     = PC_INC;
    mem_cmd    = MEM_NONE;
    halted     = 1'b0;

    case (state)
      S_RST: begin
        reset_pc   = 1'b1;
        load_pc    = 1'b1;
        state_next = S_IF1;
      end

      S_IF1: begin
        addr_sel = 1'b1;
        mem_cmd  = MEM_READ;
        if (wait_done) state_next = S_IF2;
      end

      S_IF2: begin
        addr_sel   = 1'b1;
        mem_cmd    = MEM_READ;
        load_ir    = 1'b1;
        state_next = S_UPD_PC;
      end

      S_UPD_PC: begin
        load_pc    = 1'b1;
        pc_sel     = PC_INC;
        state_next = S_DECODE;
      end

      S_DECODE: begin
        case (opcode)
          3'b110: begin
            if (op == 2'b10)      state_next = S_MOVI;
            else if (op == 2'b00) state_next = S_GET_B;
            else                  state_next = S_UNDEF;
          end
          3'b101: state_next = (op == 2'b11) ? S_GET_B : S_GET_A;
          3'b011: state_next = (op == 2'b00) ? S_LD_A : S_UNDEF;
          3'b100: state_next = (op == 2'b00) ? S_ST_A : S_UNDEF;
          3'b001: state_next = (op == 2'b00) ? S_BR : S_UNDEF;
          3'b010: begin
            if (op == 2'b11)                       state_next = S_BL;
            else if ((op == 2'b00) || (op == 2'b10)) state_next = S_BX_B;
            else                                   state_next = S_UNDEF;
          end
          3'b111:  state_next = S_HALT;
          default: state_next = S_UNDEF;
        endcase
      end

      S_MOVI: begin
        write      = 1'b1;
        nsel       = NSEL_RN;
        vsel       = VSEL_IMM;
        state_next = S_IF1;
      end

      S_GET_A: begin
        loada      = 1'b1;
        nsel       = NSEL_RN;
        state_next = S_GET_B;
      end

      S_GET_B: begin
        loadb      = 1'b1;
        nsel       = NSEL_RM;
        state_next = S_EXEC;
      end

      S_EXEC: begin
        loadc      = 1'b1;
        asel       = is_pass_a;
        loads      = is_cmp;
        state_next = is_cmp ? S_IF1 : S_WB;
      end

      S_WB: begin
        write      = 1'b1;
        nsel       = NSEL_RD;
        vsel       = VSEL_C;
        state_next = S_IF1;
      end

      S_LD_A: begin
        loada      = 1'b1;
        nsel       = NSEL_RN;
        state_next = S_LD_C;
      end

      S_LD_C: begin
        loadc      = 1'b1;
        bsel       = 1'b1;
        state_next = S_LD_ADDR;
      end

      S_LD_ADDR: begin
        load_addr  = 1'b1;
        state_next = S_LD_MEM;
      end

      S_LD_MEM: begin
        mem_cmd  = MEM_READ;
        addr_sel = 1'b0;
        if (wait_done) state_next = S_LD_WB;
      end

      // Read stays asserted so mdata is still driven during the write-back.
      S_LD_WB: begin
        mem_cmd    = MEM_READ;
        write      = 1'b1;
        nsel       = NSEL_RD;
        vsel       = VSEL_MDATA;
        state_next = S_IF1;
      end

      S_ST_A: begin
        loada      = 1'b1;
        nsel       = NSEL_RN;
        state_next = S_ST_C;
      end

      S_ST_C: begin
        loadc      = 1'b1;
        bsel       = 1'b1;
        state_next = S_ST_ADDR;
      end

      S_ST_ADDR: begin
        load_addr  = 1'b1;
        state_next = S_ST_B;
      end

      S_ST_B: begin
        loadb      = 1'b1;
        nsel       = NSEL_RD;
        state_next = S_ST_PASS;
      end

      S_ST_PASS: begin
        loadc      = 1'b1;
        asel       = 1'b1;
        state_next = S_ST_MEM;
      end

      S_ST_MEM: begin
        mem_cmd    = MEM_WRITE;
        state_next = S_IF1;
      end

      S_BR: begin
        if (br_taken) begin
          load_pc = 1'b1;
          pc_sel  = PC_REL;
        end
        state_next = S_IF1;
      end

      // PC already holds PC+1 from UPD_PC, which is the link value.
      S_BL: begin
        write      = 1'b1;
        nsel       = NSEL_RN;
        vsel       = VSEL_PC;
        load_pc    = 1'b1;
        pc_sel     = PC_REL;
        state_next = S_IF1;
      end

      S_BX_B: begin
        loadb      = 1'b1;
        nsel       = NSEL_RD;
        state_next = S_BX_C;
      end

      S_BX_C: begin
        loadc      = 1'b1;
        asel       = 1'b1;
        state_next = S_BX_J;
      end

      S_BX_J: begin
        load_pc = 1'b1;
        pc_sel  = PC_REG;
        if (op == 2'b10) begin
          write = 1'b1;
          nsel  = NSEL_RN;
          vsel  = VSEL_PC;
        end
        state_next = S_IF1;
      end

      S_HALT: begin
        halted     = 1'b1;
        state_next = S_HALT;
      end

      S_UNDEF: begin
`ifdef CPU_CTRL_TRAP_EN
        halted     = 1'b1;
        state_next = S_UNDEF;
`else
        state_next = S_IF1;
`endif
      end

      default: state_next = S_RST;
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl_fsm_v2.sv
// tb_cpu_ctrl_fsm_v2: random instruction stream checked cycle by cycle
// against a per-instruction micro-operation model.
module tb_cpu_ctrl_fsm_v2;

  localparam int MEM_LAT = 3;
  localparam int HOLD    = 12;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] opcode = 3'b000;
  logic [1:0] op = 2'b00;
  logic [2:0] cond = 3'b000;
  logic       Z = 1'b0, N = 1'b0, V = 1'b0;

  logic [2:0] nsel;
  logic [1:0] vsel, pc_sel, mem_cmd;
  logic       write, loada, loadb, loadc, loads, asel, bsel;
  logic       load_ir, load_pc, reset_pc, load_addr, addr_sel, halted;

  typedef struct packed {
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       write, loada, loadb, loadc, loads, asel, bsel;
    logic       load_ir, load_pc, reset_pc, load_addr, addr_sel;
    logic [1:0] pc_sel;
    logic [1:0] mem_cmd;
    logic       halted;
  } ctl_t;

  ctl_t  got;
  ctl_t  exp_q[$];
  string tag_q[$];
  int    n_chk  = 0;
  int    n_pass = 0;

  cpu_ctrl_fsm_v2 #(.MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .op(op), .cond(cond),
    .Z(Z), .N(N), .V(V),
    .nsel(nsel), .vsel(vsel), .write(write), .loada(loada), .loadb(loadb),
    .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel),
    .load_ir(load_ir), .load_pc(load_pc), .reset_pc(reset_pc),
    .load_addr(load_addr), .addr_sel(addr_sel), .pc_sel(pc_sel),
    .mem_cmd(mem_cmd), .halted(halted)
  );

  always #5 clk = ~clk;

  assign got = {nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel,
                load_ir, load_pc, reset_pc, load_addr, addr_sel,
                pc_sel, mem_cmd, halted};

  task automatic chk(input string tag, input ctl_t obs, input ctl_t req);
    n_chk++;
    if (obs === req) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, req, $time);
  endtask

  function automatic ctl_t dflt();
    ctl_t c;
    c = '0;
    c.nsel = 3'b001;
    c.vsel = 2'b11;
    return c;
  endfunction

  function automatic void push(input ctl_t c, input string tag);
    exp_q.push_back(c);
    tag_q.push_back(tag);
  endfunction

  // Expected per-cycle controls for one instruction, starting at its fetch.
  // Returns 1 when the instruction leaves the controller parked (needs reset).
  function automatic bit build_expect(input logic [2:0] opc, input logic [1:0] o,
                                      input logic [2:0] c, input logic z,
                                      input logic n, input logic v);
    ctl_t e;
    bit   taken;
    bit   parked = 1'b0;
    for (int i = 0; i < MEM_LAT; i++) begin
      e = dflt(); e.addr_sel = 1; e.mem_cmd = 2'b10; push(e, "fetch_wait");
    end
    e = dflt(); e.addr_sel = 1; e.mem_cmd = 2'b10; e.load_ir = 1; push(e, "fetch_ir");
    e = dflt(); e.load_pc = 1; push(e, "pc_inc");
    push(dflt(), "decode");

    if (opc == 3'b110 && o == 2'b10) begin
      e = dflt(); e.write = 1; e.nsel = 3'b100; e.vsel = 2'b01; push(e, "movi");
    end else if ((opc == 3'b110 && o == 2'b00) || opc == 3'b101) begin
      if (opc == 3'b101 && o != 2'b11) begin
        e = dflt(); e.loada = 1; e.nsel = 3'b100; push(e, "alu_get_a");
      end
      e = dflt(); e.loadb = 1; push(e, "alu_get_b");
      e = dflt(); e.loadc = 1;
      e.asel  = (opc == 3'b110) || (o == 2'b11);
      e.loads = (opc == 3'b101) && (o == 2'b01);
      push(e, "alu_exec");
      if (!(opc == 3'b101 && o == 2'b01)) begin
        e = dflt(); e.write = 1; e.nsel = 3'b010; e.vsel = 2'b11; push(e, "alu_wb");
      end
    end else if (opc == 3'b011 && o == 2'b00) begin
      e = dflt(); e.loada = 1; e.nsel = 3'b100; push(e, "ldr_a");
      e = dflt(); e.loadc = 1; e.bsel = 1; push(e, "ldr_c");
      e = dflt(); e.load_addr = 1; push(e, "ldr_addr");
      for (int i = 0; i < MEM_LAT; i++) begin
        e = dflt(); e.mem_cmd = 2'b10; push(e, "ldr_mem");
      end
      e = dflt(); e.mem_cmd = 2'b10; e.write = 1; e.nsel = 3'b010; e.vsel = 2'b00;
      push(e, "ldr_wb");
    end else if (opc == 3'b100 && o == 2'b00) begin
      e = dflt(); e.loada = 1; e.nsel = 3'b100; push(e, "str_a");
      e = dflt(); e.loadc = 1; e.bsel = 1; push(e, "str_c");
      e = dflt(); e.load_addr = 1; push(e, "str_addr");
      e = dflt(); e.loadb = 1; e.nsel = 3'b010; push(e, "str_b");
      e = dflt(); e.loadc = 1; e.asel = 1; push(e, "str_pass");
      e = dflt(); e.mem_cmd = 2'b01; push(e, "str_mem");
    end else if (opc == 3'b001 && o == 2'b00) begin
      case (c)
        3'd0:    taken = 1;
        3'd1:    taken = z;
        3'd2:    taken = !z;
        3'd3:    taken = n != v;
        3'd4:    taken = (n != v) || z;
        default: taken = 0;
      endcase
      e = dflt();
      if (taken) begin e.load_pc = 1; e.pc_sel = 2'b01; end
      push(e, "branch");
    end else if (opc == 3'b010 && o == 2'b11) begin
      e = dflt(); e.write = 1; e.nsel = 3'b100; e.vsel = 2'b10;
      e.load_pc = 1; e.pc_sel = 2'b01; push(e, "bl");
    end else if (opc == 3'b010 && (o == 2'b00 || o == 2'b10)) begin
      e = dflt(); e.loadb = 1; e.nsel = 3'b010; push(e, "bx_b");
      e = dflt(); e.loadc = 1; e.asel = 1; push(e, "bx_c");
      e = dflt(); e.load_pc = 1; e.pc_sel = 2'b10;
      if (o == 2'b10) begin e.write = 1; e.nsel = 3'b100; e.vsel = 2'b10; end
      push(e, "bx_jump");
    end else if (opc == 3'b111) begin
      for (int i = 0; i < HOLD; i++) begin
        e = dflt(); e.halted = 1; push(e, "halt");
      end
      parked = 1'b1;
    end else begin
`ifdef CPU_CTRL_TRAP_EN
      for (int i = 0; i < HOLD; i++) begin
        e = dflt(); e.halted = 1; push(e, "trap");
      end
      parked = 1'b1;
`else
      push(dflt(), "undef_nop");
`endif
    end
    return parked;
  endfunction

  task automatic do_reset();
    ctl_t e;
    e = dflt(); e.reset_pc = 1; e.load_pc = 1;
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("reset_state", got, e);
    end
    reset = 1'b0;
  endtask

  // Runs one instruction; IR fields and flags change after the first fetch
  // cycle is checked, as the controller is then insensitive to them.
  task automatic run_instr(input logic [2:0] opc, input logic [1:0] o,
                           input logic [2:0] c, input logic z, input logic n,
                           input logic v, input bit reset_after);
    bit parked;
    exp_q.delete();
    tag_q.delete();
    parked = build_expect(opc, o, c, z, n, v);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      chk(tag_q[i], got, exp_q[i]);
      if (i == 0) begin
        opcode = opc; op = o; cond = c; Z = z; N = n; V = v;
      end
    end
    if (parked || reset_after) do_reset();
  endtask

  initial begin
    do_reset();
    run_instr(3'b110, 2'b10, 3'd0, 0, 0, 0, 0);  // MOV R0,#5
    run_instr(3'b101, 2'b01, 3'd0, 1, 0, 0, 0);  // CMP
    run_instr(3'b001, 2'b00, 3'd1, 1, 0, 0, 0);  // BEQ taken
    run_instr(3'b101, 2'b01, 3'd0, 0, 0, 0, 0);  // CMP
    run_instr(3'b001, 2'b00, 3'd1, 0, 0, 0, 0);  // BEQ not taken
    run_instr(3'b001, 2'b00, 3'd4, 0, 1, 0, 0);  // BLE taken via N^V
    run_instr(3'b001, 2'b00, 3'd5, 1, 1, 0, 0);  // reserved cond
    run_instr(3'b011, 2'b00, 3'd0, 0, 0, 0, 0);  // LDR
    run_instr(3'b010, 2'b10, 3'd0, 0, 0, 0, 0);  // BLX
    run_instr(3'b010, 2'b00, 3'd0, 0, 0, 0, 0);  // BX
    run_instr(3'b010, 2'b11, 3'd0, 0, 0, 0, 0);  // BL
    run_instr(3'b101, 2'b00, 3'd0, 0, 0, 0, 0);  // ADD
    run_instr(3'b101, 2'b11, 3'd0, 0, 0, 0, 0);  // MVN
    run_instr(3'b110, 2'b00, 3'd0, 0, 0, 0, 0);  // MOV reg
    run_instr(3'b000, 2'b00, 3'd0, 0, 0, 0, 0);  // undefined
    run_instr(3'b100, 2'b00, 3'd0, 0, 0, 0, 1);  // STR, reset in ST_MEM
    run_instr(3'b111, 2'b00, 3'd0, 0, 0, 0, 0);  // HALT
    for (int k = 0; k < 200; k++) begin
      run_instr(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
